control_sequencer: RTL and testbench

- Hardwired Moore control unit that drives every strobe input of the 32-bit datapath: register out/in enables, ALU op selects, read, IncPC.
- Consumes the datapath's IR output and steps each instruction through fetch and execute T-states.
- Sits beside the datapath. It is the initiator; the datapath is the responder.
- Memory data reaches the datapath on Mdatain. That path is external to this block.

---
 rtl/control_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//
// Hardwired Moore control unit for the 32-bit datapath. It walks every
// instruction through the common fetch T-states T0..T2 and then through the
// execute T-states that the opcode in IR needs. All datapath strobes are
// decoded from the registered state and the IR fields.
//
// Ports:
//   clk            rising-edge clock shared with the datapath
//   clear          synchronous active-high reset; forces every strobe low
//   IR[31:0]       instruction register from the datapath
//   mem_rdy        memory ready, present only when MEM_WAIT_EN is defined
//   Rout/Rin[15:0] one-hot general register out / in enables
//   HIout..MDRout  bus source selects (at most one is high)
//   PCin..MDRin    register load enables
//   read           MDR takes Mdatain instead of the bus
//   AND..IncPC     ALU operation selects (at most one is high)
//   BAout          tied low
//   run            high in every state except HALT and RESET
//   t_state[3:0]   T0..T6 = 0..6, HALT = E, RESET = F
//
// Parameter RST_PC_HOLD (1..15): cycles spent in RESET after clear drops.
//
// Optional build macro MEM_WAIT_EN: adds mem_rdy and stretches T1 until
// memory reports ready. Without it T1 always lasts exactly one cycle.

module control_sequencer #(
   parameter int unsigned RST_PC_HOLD = 1
) (
   input  logic        clk,
   input  logic        clear,
   input  logic [31:0] IR,
`ifdef MEM_WAIT_EN
   input  logic        mem_rdy,
`endif
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        HIout,
   output logic        LOout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        PCout,
   output logic        MDRout,
   output logic        PCin,
   output logic        IRin,
   output logic        MARin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        Zin,
   output logic        MDRin,
   output logic        read,
   output logic        AND,
   output logic        OR,
   output logic        ADD,
   output logic        SUB,
   output logic        MUL,
   output logic        DIV,
   output logic        SHR,
   output logic        SHL,
   output logic        ROR,
   output logic        ROL,
   output logic        NEG,
   output logic        NOT,
   output logic        IncPC,
   output logic        BAout,
   output logic        run,
   output logic [3:0]  t_state
);

   typedef enum logic [3:0] {
      T0    = 4'h0,
      T1    = 4'h1,
      T2    = 4'h2,
      T3    = 4'h3,
      T4    = 4'h4,
      T5    = 4'h5,
      T6    = 4'h6,
      HALT  = 4'hE,
      RESET = 4'hF
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] HOLD_LAST = 4'(RST_PC_HOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] holdCnt_q, holdCnt_d;

   logic [4:0]  opcode;
   logic [15:0] selRa, selRb, selRc;
   logic        isAluR, isMulDiv, isNegNot, isHalt;
   logic        pcLoadOk;
   logic        unusedIrBits;

   // Field decode. The low IR bits carry no meaning for this instruction set.
   assign opcode       = IR[31:27];
   assign selRa        = 16'h0001 << IR[26:23];
   assign selRb        = 16'h0001 << IR[22:19];
   assign selRc        = 16'h0001 << IR[18:15];
   assign unusedIrBits = ^IR[14:0];

   assign isAluR   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_SHR) ||
                     (opcode == OP_SHL) || (opcode == OP_ROR) || (opcode == OP_ROL) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
   assign isMulDiv = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign isNegNot = (opcode == OP_NEG) || (opcode == OP_NOT);
   assign isHalt   = (opcode == OP_HALT);

   // PC may only be loaded in the T1 cycle that actually ends the fetch read.
`ifdef MEM_WAIT_EN
   assign pcLoadOk = mem_rdy;
`else
   assign pcLoadOk = 1'b1;
`endif

   assign t_state = state_q;

   // Next-state logic. Unknown opcodes fall out of T3 like a nop, and the
   // RESET hold counter releases into T0 after RST_PC_HOLD quiet cycles.
   always_comb begin
      state_d   = state_q;
      holdCnt_d = holdCnt_q;
      case (state_q)
         RESET: begin
            if (holdCnt_q == HOLD_LAST) begin
               state_d   = T0;
               holdCnt_d = 4'd0;
            end else begin
               holdCnt_d = holdCnt_q + 4'd1;
            end
         end
         T0: state_d = T1;
         T1: begin
            if (pcLoadOk) begin
               state_d = T2;
            end
         end
         T2: state_d = T3;
         T3: begin
            if (isHalt) begin
               state_d = HALT;
            end else if (isAluR || isMulDiv || isNegNot) begin
               state_d = T4;
            end else begin
               state_d = T0;
            end
         end
         T4: state_d = (isAluR || isMulDiv) ? T5 : T0;
         T5: state_d = isMulDiv ? T6 : T0;
         T6: state_d = T0;
         HALT: state_d = HALT;
         default: state_d = RESET;
      endcase
   end

   // State register with synchronous clear.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q   <= RESET;
         holdCnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         holdCnt_q <= holdCnt_d;
      end
   end

   // Strobe decode. Everything is held low while clear is high so that an
   // instruction interrupted by clear cannot issue a partial register write.
   always_comb begin
      Rout     = 16'h0000;
      Rin      = 16'h0000;
      HIout    = 1'b0;
      LOout    = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      PCout    = 1'b0;
      MDRout   = 1'b0;
      PCin     = 1'b0;
      IRin     = 1'b0;
      MARin    = 1'b0;
      Yin      = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      Zin      = 1'b0;
      MDRin    = 1'b0;
      read     = 1'b0;
      AND      = 1'b0;
      OR       = 1'b0;
      ADD      = 1'b0;
      SUB      = 1'b0;
      MUL      = 1'b0;
      DIV      = 1'b0;
      SHR      = 1'b0;
      SHL      = 1'b0;
      ROR      = 1'b0;
      ROL      = 1'b0;
      NEG      = 1'b0;
      NOT      = 1'b0;
      IncPC    = 1'b0;
      BAout    = 1'b0;
      run      = 1'b0;
      if (!clear) begin
         case (state_q)
            T0: begin
               run   = 1'b1;
               PCout = 1'b1;
               MARin = 1'b1;
               IncPC = 1'b1;
               Zin   = 1'b1;
            end
            T1: begin
               run     = 1'b1;
               Zlowout = 1'b1;
               read    = 1'b1;
               MDRin   = 1'b1;
               PCin    = pcLoadOk;
            end
            T2: begin
               run    = 1'b1;
               MDRout = 1'b1;
               IRin   = 1'b1;
            end
            T3: begin
               run = 1'b1;
               if (isAluR) begin
                  Rout = selRb;
                  Yin  = 1'b1;
               end else if (isMulDiv) begin
                  Rout = selRa;
                  Yin  = 1'b1;
               end else if (isNegNot) begin
                  Rout = selRb;
                  NEG  = (opcode == OP_NEG);
                  NOT  = (opcode == OP_NOT);
                  Zin  = 1'b1;
               end
            end
            T4: begin
               run = 1'b1;
               if (isAluR) begin
                  Rout = selRc;
                  Zin  = 1'b1;
                  ADD  = (opcode == OP_ADD);
                  SUB  = (opcode == OP_SUB);
                  SHR  = (opcode == OP_SHR);
                  SHL  = (opcode == OP_SHL);
                  ROR  = (opcode == OP_ROR);
                  ROL  = (opcode == OP_ROL);
                  AND  = (opcode == OP_AND);
                  OR   = (opcode == OP_OR);
               end else if (isMulDiv) begin
                  Rout = selRb;
                  Zin  = 1'b1;
                  MUL  = (opcode == OP_MUL);
                  DIV  = (opcode == OP_DIV);
               end else if (isNegNot) begin
                  Zlowout = 1'b1;
                  Rin     = selRa;
               end
            end
            T5: begin
               run = 1'b1;
               if (isAluR) begin
                  Zlowout = 1'b1;
                  Rin     = selRa;
               end else if (isMulDiv) begin
                  Zlowout = 1'b1;
                  LOin    = 1'b1;
               end
            end
            T6: begin
               run      = 1'b1;
               Zhighout = 1'b1;
               HIin     = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//
// Directed bench for control_sequencer. Each scenario task steps the
// sequencer one clock at a time and compares the T-state, Rout, Rin and the
// packed control strobes against hand-written per-cycle expectations.

module tb_control_sequencer;

   typedef struct packed {
      logic [3:0]  t;
      logic [15:0] rout;
      logic [15:0] rin;
      logic [29:0] ctl;
   } expVec;

   typedef struct packed {
      logic [31:0] ir;
      logic [29:0] opMask;
      logic [15:0] routB;
      logic [15:0] routC;
      logic [15:0] rinA;
   } aluCase;

   // Bit positions of each strobe inside ctlBus.
   localparam logic [29:0] mHIout    = 30'h1 << 29;
   localparam logic [29:0] mLOout    = 30'h1 << 28;
   localparam logic [29:0] mZhighout = 30'h1 << 27;
   localparam logic [29:0] mZlowout  = 30'h1 << 26;
   localparam logic [29:0] mPCout    = 30'h1 << 25;
   localparam logic [29:0] mMDRout   = 30'h1 << 24;
   localparam logic [29:0] mPCin     = 30'h1 << 23;
   localparam logic [29:0] mIRin     = 30'h1 << 22;
   localparam logic [29:0] mMARin    = 30'h1 << 21;
   localparam logic [29:0] mYin      = 30'h1 << 20;
   localparam logic [29:0] mHIin     = 30'h1 << 19;
   localparam logic [29:0] mLOin     = 30'h1 << 18;
   localparam logic [29:0] mZin      = 30'h1 << 17;
   localparam logic [29:0] mMDRin    = 30'h1 << 16;
   localparam logic [29:0] mRead     = 30'h1 << 15;
   localparam logic [29:0] mAND      = 30'h1 << 14;
   localparam logic [29:0] mOR       = 30'h1 << 13;
   localparam logic [29:0] mADD      = 30'h1 << 12;
   localparam logic [29:0] mSUB      = 30'h1 << 11;
   localparam logic [29:0] mMUL      = 30'h1 << 10;
   localparam logic [29:0] mDIV      = 30'h1 << 9;
   localparam logic [29:0] mSHR      = 30'h1 << 8;
   localparam logic [29:0] mSHL      = 30'h1 << 7;
   localparam logic [29:0] mROR      = 30'h1 << 6;
   localparam logic [29:0] mROL      = 30'h1 << 5;
   localparam logic [29:0] mNEG      = 30'h1 << 4;
   localparam logic [29:0] mNOT      = 30'h1 << 3;
   localparam logic [29:0] mIncPC    = 30'h1 << 2;
   localparam logic [29:0] mRun      = 30'h1 << 0;

   localparam logic [29:0] F0 = mPCout | mMARin | mIncPC | mZin | mRun;
   localparam logic [29:0] F1 = mZlowout | mPCin | mRead | mMDRin | mRun;
   localparam logic [29:0] F2 = mMDRout | mIRin | mRun;

   logic        clk;
   logic        clear;
   logic [31:0] IR;
`ifdef MEM_WAIT_EN
   logic        mem_rdy;
`endif
   logic [15:0] Rout, Rin;
   logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout;
   logic PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, read;
   logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
   logic BAout, run;
   logic [3:0]  t_state;
   logic [29:0] ctlBus;

   int vectorCount = 0;
   int missCount   = 0;

   control_sequencer #(.RST_PC_HOLD(1)) dut (
      .clk(clk), .clear(clear), .IR(IR),
`ifdef MEM_WAIT_EN
      .mem_rdy(mem_rdy),
`endif
      .Rout(Rout), .Rin(Rin),
      .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .PCout(PCout), .MDRout(MDRout),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin), .HIin(HIin),
      .LOin(LOin), .Zin(Zin), .MDRin(MDRin), .read(read),
      .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
      .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
      .IncPC(IncPC), .BAout(BAout), .run(run), .t_state(t_state)
   );

   assign ctlBus = {HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
                    PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, read,
                    AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT,
                    IncPC, BAout, run};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic expVec mk(input logic [3:0] t, input logic [15:0] ro,
                                input logic [15:0] ri, input logic [29:0] c);
      mk = '{t: t, rout: ro, rin: ri, ctl: c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // clear held three cycles, then one quiet RESET cycle before fetch starts.
   task automatic test_reset();
      expVec obs;
      expVec want;
      want = mk(4'hF, 16'h0000, 16'h0000, 30'h0);
      clear = 1'b1;
      IR    = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            tick();
         end else begin
            clear = 1'b0;
            #1;
         end
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== want) begin
            missCount++;
            $display("[TB] FAIL reset cycle %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, want.t, want.rout, want.rin, want.ctl);
         end
      end
   endtask

   task automatic test_add();
      expVec tbl [6];
      expVec obs;
      tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[2] = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[3] = mk(4'h3, 16'h0008, 16'h0000, mYin | mRun);
      tbl[4] = mk(4'h4, 16'h0008, 16'h0000, mADD | mZin | mRun);
      tbl[5] = mk(4'h5, 16'h0000, 16'h0010, mZlowout | mRun);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) IR = 32'h1A19_8000;
         #1;
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== tbl[i]) begin
            missCount++;
            $display("[TB] FAIL add step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
         end
      end
   endtask

   task automatic test_mul();
      expVec tbl [7];
      expVec obs;
      tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[2] = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[3] = mk(4'h3, 16'h0002, 16'h0000, mYin | mRun);
      tbl[4] = mk(4'h4, 16'h0004, 16'h0000, mMUL | mZin | mRun);
      tbl[5] = mk(4'h5, 16'h0000, 16'h0000, mZlowout | mLOin | mRun);
      tbl[6] = mk(4'h6, 16'h0000, 16'h0000, mZhighout | mHIin | mRun);
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i == 0) IR = {5'b01111, 4'd1, 4'd2, 4'd0, 15'h0000};
         #1;
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== tbl[i]) begin
            missCount++;
            $display("[TB] FAIL mul step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
         end
      end
   endtask

   task automatic test_not();
      expVec tbl [5];
      expVec obs;
      tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[2] = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[3] = mk(4'h3, 16'h0020, 16'h0000, mNOT | mZin | mRun);
      tbl[4] = mk(4'h4, 16'h0000, 16'h0080, mZlowout | mRun);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) IR = {5'b10010, 4'd7, 4'd5, 4'd0, 15'h0000};
         #1;
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== tbl[i]) begin
            missCount++;
            $display("[TB] FAIL not step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
         end
      end
   endtask

   // Remaining R-type ops back to back, with junk in the unused low IR bits.
   task automatic test_alu_ops();
      aluCase cases [7];
      expVec  tbl [6];
      expVec  obs;
      cases[0] = '{{5'b00100, 4'd15, 4'd0,  4'd9,  15'h2A5A}, mSUB, 16'h0001, 16'h0200, 16'h8000};
      cases[1] = '{{5'b00101, 4'd2,  4'd6,  4'd1,  15'h2A5A}, mSHR, 16'h0040, 16'h0002, 16'h0004};
      cases[2] = '{{5'b00111, 4'd0,  4'd0,  4'd0,  15'h2A5A}, mSHL, 16'h0001, 16'h0001, 16'h0001};
      cases[3] = '{{5'b01000, 4'd11, 4'd12, 4'd13, 15'h2A5A}, mROR, 16'h1000, 16'h2000, 16'h0800};
      cases[4] = '{{5'b01001, 4'd5,  4'd14, 4'd8,  15'h2A5A}, mROL, 16'h4000, 16'h0100, 16'h0020};
      cases[5] = '{{5'b01010, 4'd9,  4'd10, 4'd7,  15'h2A5A}, mAND, 16'h0400, 16'h0080, 16'h0200};
      cases[6] = '{{5'b01011, 4'd3,  4'd1,  4'd15, 15'h2A5A}, mOR,  16'h0002, 16'h8000, 16'h0008};
      for (int k = 0; k < 7; k++) begin
         tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
         tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1);
         tbl[2] = mk(4'h2, 16'h0000, 16'h0000, F2);
         tbl[3] = mk(4'h3, cases[k].routB, 16'h0000, mYin | mRun);
         tbl[4] = mk(4'h4, cases[k].routC, 16'h0000, cases[k].opMask | mZin | mRun);
         tbl[5] = mk(4'h5, 16'h0000, cases[k].rinA, mZlowout | mRun);
         for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) IR = cases[k].ir;
            #1;
            obs = {t_state, Rout, Rin, ctlBus};
            vectorCount++;
            if (obs !== tbl[i]) begin
               missCount++;
               $display("[TB] FAIL alu%0d step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                        k, i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
            end
         end
      end
   endtask

   // div Ra=13 Rb=6, then neg Ra=0 Rb=15.
   task automatic test_div_neg();
      expVec tbl [12];
      expVec obs;
      tbl[0]  = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1]  = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[2]  = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[3]  = mk(4'h3, 16'h2000, 16'h0000, mYin | mRun);
      tbl[4]  = mk(4'h4, 16'h0040, 16'h0000, mDIV | mZin | mRun);
      tbl[5]  = mk(4'h5, 16'h0000, 16'h0000, mZlowout | mLOin | mRun);
      tbl[6]  = mk(4'h6, 16'h0000, 16'h0000, mZhighout | mHIin | mRun);
      tbl[7]  = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[8]  = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[9]  = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[10] = mk(4'h3, 16'h8000, 16'h0000, mNEG | mZin | mRun);
      tbl[11] = mk(4'h4, 16'h0000, 16'h0001, mZlowout | mRun);
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i == 0) IR = {5'b10000, 4'd13, 4'd6, 4'd0, 15'h0000};
         if (i == 7) IR = {5'b10001, 4'd0, 4'd15, 4'd0, 15'h0000};
         #1;
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== tbl[i]) begin
            missCount++;
            $display("[TB] FAIL divneg step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
         end
      end
   endtask

   // nop plus opcodes with no defined meaning: all end after an empty T3.
   task automatic test_nop();
      logic [4:0] ops [4];
      expVec tbl [4];
      expVec obs;
      ops[0] = 5'b11010;
      ops[1] = 5'b11111;
      ops[2] = 5'b00000;
      ops[3] = 5'b01100;
      tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[2] = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[3] = mk(4'h3, 16'h0000, 16'h0000, mRun);
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) IR = {ops[k], 4'd6, 4'd9, 4'd12, 15'h7FFF};
            #1;
            obs = {t_state, Rout, Rin, ctlBus};
            vectorCount++;
            if (obs !== tbl[i]) begin
               missCount++;
               $display("[TB] FAIL nop op=%b step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                        ops[k], i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
            end
         end
      end
   endtask

   // clear raised during T4 of an add must kill the strobes in that cycle.
   task automatic test_clear_mid();
      expVec tbl [8];
      expVec obs;
      tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[2] = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[3] = mk(4'h3, 16'h0004, 16'h0000, mYin | mRun);
      tbl[4] = mk(4'h4, 16'h0000, 16'h0000, 30'h0);
      tbl[5] = mk(4'hF, 16'h0000, 16'h0000, 30'h0);
      tbl[6] = mk(4'hF, 16'h0000, 16'h0000, 30'h0);
      tbl[7] = mk(4'h0, 16'h0000, 16'h0000, F0);
      for (int i = 0; i < 8; i++) begin
         if (i == 6) begin
            clear = 1'b0;
         end else begin
            tick();
         end
         if (i == 0) IR = {5'b00011, 4'd8, 4'd2, 4'd11, 15'h0000};
         if (i == 4) clear = 1'b1;
         #1;
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== tbl[i]) begin
            missCount++;
            $display("[TB] FAIL clearmid step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
         end
         if (i == 7) break;
      end
      // Leave the sequencer in the cycle before T0, like the other tasks.
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

`ifdef MEM_WAIT_EN
   // T1 stretched by three not-ready cycles; PCin only in the final one.
   task automatic test_mem_wait();
      expVec tbl [7];
      expVec obs;
      tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1 & ~mPCin);
      tbl[2] = mk(4'h1, 16'h0000, 16'h0000, F1 & ~mPCin);
      tbl[3] = mk(4'h1, 16'h0000, 16'h0000, F1 & ~mPCin);
      tbl[4] = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[5] = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[6] = mk(4'h3, 16'h0000, 16'h0000, mRun);
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i == 0) begin
            IR      = {5'b11111, 4'd0, 4'd0, 4'd0, 15'h0000};
            mem_rdy = 1'b0;
         end
         if (i == 4) mem_rdy = 1'b1;
         #1;
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== tbl[i]) begin
            missCount++;
            $display("[TB] FAIL memwait step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
         end
      end
   endtask
`endif

   // halt parks the sequencer; only clear brings it back through RESET.
   task automatic test_halt();
      expVec tbl [4];
      expVec want;
      expVec obs;
      tbl[0] = mk(4'h0, 16'h0000, 16'h0000, F0);
      tbl[1] = mk(4'h1, 16'h0000, 16'h0000, F1);
      tbl[2] = mk(4'h2, 16'h0000, 16'h0000, F2);
      tbl[3] = mk(4'h3, 16'h0000, 16'h0000, mRun);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) IR = {5'b11011, 4'd3, 4'd3, 4'd3, 15'h0000};
         #1;
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== tbl[i]) begin
            missCount++;
            $display("[TB] FAIL halt fetch step %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, tbl[i].t, tbl[i].rout, tbl[i].rin, tbl[i].ctl);
         end
      end
      want = mk(4'hE, 16'h0000, 16'h0000, 30'h0);
      for (int i = 0; i < 21; i++) begin
         if (i < 20) begin
            tick();
         end else begin
            clear = 1'b1;
            #1;
         end
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== want) begin
            missCount++;
            $display("[TB] FAIL halt park %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, want.t, want.rout, want.rin, want.ctl);
         end
      end
      want = mk(4'hF, 16'h0000, 16'h0000, 30'h0);
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            tick();
         end else begin
            clear = 1'b0;
            #1;
         end
         obs = {t_state, Rout, Rin, ctlBus};
         vectorCount++;
         if (obs !== want) begin
            missCount++;
            $display("[TB] FAIL halt clear %0d: got t=%h Rout=%h Rin=%h ctl=%h, want t=%h Rout=%h Rin=%h ctl=%h",
                     i, obs.t, obs.rout, obs.rin, obs.ctl, want.t, want.rout, want.rin, want.ctl);
         end
      end
   endtask

   initial begin
      clear = 1'b1;
      IR    = 32'h0000_0000;
`ifdef MEM_WAIT_EN
      mem_rdy = 1'b1;
`endif
      test_reset();
      test_add();
      test_mul();
      test_not();
      test_alu_ops();
      test_div_neg();
      test_nop();
      test_clear_mid();
`ifdef MEM_WAIT_EN
      test_mem_wait();
`endif
      test_halt();
      test_add();
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
